framebuffer_writer: RTL
=======================

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 SHALL have parameter BUFFER_WIDTH, default 160, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter BUFFER_HEIGHT, default 120, meaning framebuffer height in pixels.
REQ-003 SHALL have parameter BUFFER_DATA_WIDTH, default 12, meaning pixel width, packed {b[11:8], g[7:4], r[3:0]}.
REQ-004 SHALL have parameter BUFFER_ADDR_WIDTH, default $clog2(BUFFER_WIDTH*BUFFER_HEIGHT), meaning write address width.
REQ-005 SHALL have parameter CLEAR_COLOR, default 12'h000, meaning background fill value.
REQ-006 SHALL have clk_pixel, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have rst_pixel, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have buffer_select, input, 1, meaning the bank free for writing, driven by the display stage in the same clock domain.
REQ-009 SHALL have in_valid, input, 1, meaning a pixel write request is present.
REQ-010 SHALL have in_ready, output, 1, meaning the request is accepted this cycle.
REQ-011 SHALL have in_x, input, 8, meaning pixel column.
REQ-012 SHALL have in_y, input, 8, meaning pixel row.
REQ-013 SHALL have in_color, input, BUFFER_DATA_WIDTH, meaning pixel value.
REQ-014 SHALL have in_last, input, 1, meaning this request is the final one of the frame.
REQ-015 SHALL have wr_en, output, 1, meaning a framebuffer write strobe.
REQ-016 SHALL have wr_bank, output, 1, meaning the target bank.
REQ-017 SHALL have wr_addr, output, BUFFER_ADDR_WIDTH, meaning the write address.
REQ-018 SHALL have wr_data, output, BUFFER_DATA_WIDTH, meaning the write data.
REQ-019 SHALL have frame_done, output, 1, meaning the back buffer is complete and the block is waiting for a swap.
REQ-020 SHALL have overrun, output, 1, meaning a one-cycle pulse when a swap arrives before frame completion.
REQ-021 SHALL have drop_count, output, 16, meaning a saturating count of out-of-range requests.

Function
REQ-022 SHALL register buffer_select into bs_q every cycle; toggle = (buffer_select != bs_q).
REQ-023 SHALL implement states CLEAR, DRAW and DONE.
REQ-024 CLEAR SHALL write CLEAR_COLOR to addresses 0..W*H-1 of the latched bank, one per cycle with wr_en=1 contiguous, then enter DRAW on the cycle after writing address W*H-1.
REQ-025 in_ready SHALL be combinational and equal to (state==DRAW && !toggle).
REQ-026 An accepted request (in_valid && in_ready) at edge k SHALL produce wr_en=1, wr_addr=in_y*BUFFER_WIDTH+in_x (computed at ≥BUFFER_ADDR_WIDTH+1 bits, no truncation before the range check), wr_data=in_color, wr_bank=latched bank, all valid after edge k (1-cycle latency); otherwise wr_en=0 in DRAW and DONE.
REQ-027 An accepted request with in_x≥BUFFER_WIDTH or in_y≥BUFFER_HEIGHT SHALL be consumed without a write and SHALL increment drop_count, which saturates at 16'hFFFF.
REQ-028 An accepted request with in_last=1 SHALL move the block to DONE after its write, whether the request is in range or dropped; frame_done SHALL be 1 exactly while in DONE.
REQ-029 A toggle in any state SHALL latch bank=buffer_select, reset the clear address to 0 and enter CLEAR on the next edge; any request presented in that cycle is not accepted.
REQ-030 A toggle while in CLEAR or DRAW SHALL pulse overrun for one cycle; a toggle while in DONE SHALL NOT pulse overrun.
REQ-031 wr_bank SHALL never change value during a run of CLEAR writes.

Reset
REQ-032 While rst_pixel=1, the block SHALL set wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, frame_done=0, overrun=0 and drop_count=0, set bs_q=buffer_select, set bank=buffer_select and enter CLEAR at address 0.
REQ-033 The first edge with rst_pixel=0 SHALL present wr_en=1, wr_addr=0, wr_data=CLEAR_COLOR; reset asserted mid-CLEAR or mid-DRAW SHALL abort the operation with no further writes.

Verification
REQ-034 Reset with buffer_select=1 -> 19200 consecutive writes to bank 1, addresses 0..19199, data 12'h000, then in_ready=1.
REQ-035 In DRAW, (x=5, y=2, color=12'hABC) -> one cycle later wr_addr=325, wr_data=12'hABC, a single-cycle wr_en pulse.
REQ-036 (x=160, y=0) then (x=0, y=120, last=1) -> no writes, drop_count=2, frame_done=1.
REQ-037 buffer_select toggles in DONE -> in_ready=0 that cycle, overrun=0, a CLEAR of the new bank begins one edge later.
REQ-038 buffer_select toggles at clear address 1000 -> a one-cycle overrun pulse, CLEAR restarts at address 0 on the new bank.
REQ-039 Back-to-back valid requests for 4 cycles in DRAW -> 4 consecutive wr_en cycles, in order, with no bubbles.

Source files
------------

// File: rtl/framebuffer_writer.sv
// Pixel write front-end for a double-buffered framebuffer: clears the back bank,
// then turns (x, y, color) requests into addressed writes until the display swaps banks.
module framebuffer_writer #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter logic [BUFFER_DATA_WIDTH-1:0] CLEAR_COLOR = BUFFER_DATA_WIDTH'(12'h000)
) (
  input  logic                         clk_pixel,
  input  logic                         rst_pixel,
  input  logic                         buffer_select,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_x,
  input  logic [7:0]                   in_y,
  input  logic [BUFFER_DATA_WIDTH-1:0] in_color,
  input  logic                         in_last,
  output logic                         wr_en,
  output logic                         wr_bank,
  output logic [BUFFER_ADDR_WIDTH-1:0] wr_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] wr_data,
  output logic                         frame_done,
  output logic                         overrun,
  output logic [15:0]                  drop_count
);

  // state | meaning
  // CLEAR | filling the latched bank with CLEAR_COLOR, one address per cycle
  // DRAW  | accepting pixel requests into the latched bank
  // DONE  | frame complete, waiting for the display to swap banks
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    DRAW  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Clear counter is one bit wider so it can hold W*H as the end marker.
  localparam logic [BUFFER_ADDR_WIDTH:0] CLEAR_END =
    (BUFFER_ADDR_WIDTH+1)'(BUFFER_WIDTH * BUFFER_HEIGHT);
  localparam logic [BUFFER_ADDR_WIDTH:0] CLEAR_STEP = (BUFFER_ADDR_WIDTH+1)'(1);

  state_t                     state, state_next;
  logic                       bs_q;
  logic                       bank;
  logic [BUFFER_ADDR_WIDTH:0] clr_addr;
  logic                       toggle;
  logic                       accept;
  logic                       in_range;
  logic                       clearing;

  assign toggle     = (buffer_select != bs_q);
  assign accept     = in_valid && in_ready;
  assign in_range   = ({24'd0, in_x} < 32'(BUFFER_WIDTH)) &&
                      ({24'd0, in_y} < 32'(BUFFER_HEIGHT));
  assign clearing   = (state == CLEAR) && (clr_addr != CLEAR_END);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) state <= CLEAR;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = (state == DRAW) && !toggle;
    if (toggle) begin
      state_next = CLEAR;
    end else begin
      case (state)
        CLEAR:   if (clr_addr == CLEAR_END) state_next = DRAW;
        DRAW:    if (accept && in_last) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      bs_q       <= buffer_select;
      bank       <= buffer_select;
      clr_addr   <= '0;
      wr_en      <= 1'b0;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      bs_q    <= buffer_select;
      wr_en   <= 1'b0;
      overrun <= 1'b0;
      if (toggle) begin
        // A swap always restarts the clear; it is only an error if the frame was unfinished.
        bank     <= buffer_select;
        clr_addr <= '0;
        overrun  <= (state != DONE);
      end else if (clearing) begin
        wr_en    <= 1'b1;
        wr_bank  <= bank;
        wr_addr  <= clr_addr[BUFFER_ADDR_WIDTH-1:0];
        wr_data  <= CLEAR_COLOR;
        clr_addr <= clr_addr + CLEAR_STEP;
      end else if (accept) begin
        if (in_range) begin
          wr_en   <= 1'b1;
          wr_bank <= bank;
          wr_addr <= BUFFER_ADDR_WIDTH'({24'd0, in_y} * 32'(BUFFER_WIDTH) + {24'd0, in_x});
          wr_data <= in_color;
        end else if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule
